// File: rtl/crypto_key_reader_pkg.sv
// crypto_key_pkg: shared types and helpers for the crypto key reader.
//   state_t      : reader FSM states (IDLE, READ, DRAIN, VALID)
//   DEF_DATA_W   : default width of one key-store word
//   DEF_KEY_WORDS: default number of words per key
//   DEF_KEY_W    : default assembled key width (DEF_DATA_W*DEF_KEY_WORDS)
//   slot_base()  : first store word address of a key slot
package crypto_key_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    VALID = 2'd3
  } state_t;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_KEY_WORDS = 8;
  localparam int DEF_KEY_W     = DEF_DATA_W * DEF_KEY_WORDS;

  // Keys are stored back to back, so slot s starts at word s*key_words.
  function automatic int unsigned slot_base(input int unsigned slot,
                                            input int unsigned key_words);
    return slot * key_words;
  endfunction

endpackage

// File: rtl/crypto_key_reader_if.sv
// crypto_key_reader_if: groups the key-store read bus and the key handoff
// to the cipher core.
//   rd_en / rd_addr : store read strobe and word address (reader drives)
//   rd_data         : store read data, valid one cycle after rd_en
//   key_out         : assembled key (reader drives)
//   key_valid       : key presented to the consumer (reader drives)
//   key_ready       : consumer accepts the key
// Modports: master = key reader, slave = store/consumer side.
// The parameters must match those of the crypto_key_reader bound to it.
interface crypto_key_reader_if #(
  parameter int DATA_W    = 16,
  parameter int KEY_WORDS = 8,
  parameter int ADDR_W    = 5
);

  logic                        rd_en;
  logic [ADDR_W-1:0]           rd_addr;
  logic [DATA_W-1:0]           rd_data;
  logic [DATA_W*KEY_WORDS-1:0] key_out;
  logic                        key_valid;
  logic                        key_ready;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output key_out,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  key_out,
    input  key_valid,
    output key_ready
  );

endinterface

// File: rtl/crypto_key_reader.sv
// crypto_key_reader: fetches one key slot from the key store as KEY_WORDS
// consecutive words, assembles them into a wide key register and presents
// the key to the cipher core over a valid/ready handshake.
//
// Ports:
//   clk       : clock, rising edge
//   resetn    : asynchronous active-low reset
//   req       : fetch request, sampled only in IDLE
//   req_slot  : slot index, sampled with req
//   zeroize   : clear key buffer and abort any operation (highest priority)
//   busy      : high whenever the FSM is not IDLE
//   err       : one-cycle pulse when a request names a slot >= NUM_SLOTS
//   bus       : crypto_key_reader_if.master (store read bus + key handoff)
//
// Optional feature (macro CRYPTO_KEY_AUTOCLEAR_EN):
//   defined   : key_out is cleared on the edge that completes the handshake
//   undefined : key_out keeps the last key until the next fetch, zeroize
//               or reset
//
// Timing: the edge that samples req loads the first read address; rd_en is
// high for KEY_WORDS cycles, the store answers one cycle later, and the
// last word lands in DRAIN, so key_valid rises KEY_WORDS+1 edges after req.
module crypto_key_reader
  import crypto_key_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int KEY_WORDS = DEF_KEY_WORDS,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int ADDR_W    = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req,
  input  logic [SLOT_W-1:0]  req_slot,
  input  logic               zeroize,
  output logic               busy,
  output logic               err,
  crypto_key_reader_if.master bus
);

  localparam int KEY_W = DATA_W * KEY_WORDS;
  // Issue counter must be able to hold KEY_WORDS itself (the "all issued" mark).
  localparam int CNT_W = $clog2(KEY_WORDS + 1);

  state_t             state_reg, state_next;
  logic               rd_en_reg, rd_en_next;
  logic [ADDR_W-1:0]  rd_addr_reg, rd_addr_next;
  logic [CNT_W-1:0]   issue_cnt_reg, issue_cnt_next;
  logic               cap_en_reg, cap_en_next;
  logic [CNT_W-1:0]   cap_cnt_reg, cap_cnt_next;
  logic [KEY_W-1:0]   key_reg, key_next;
  logic               key_valid_reg, key_valid_next;
  logic               err_reg, err_next;

  logic               slot_ok;
  logic [ADDR_W-1:0]  slot_addr;
  logic [KEY_WORDS-1:0] word_we;

  assign slot_ok   = ({{(32-SLOT_W){1'b0}}, req_slot} < 32'(NUM_SLOTS));
  assign slot_addr = ADDR_W'(slot_base(32'(req_slot), unsigned'(KEY_WORDS)));

  // cap_en_reg marks a cycle in which rd_data carries the word requested one
  // cycle earlier; cap_cnt_reg says which key word it is.
  genvar gi;
  generate
    for (gi = 0; gi < KEY_WORDS; gi++) begin : g_word_we
      assign word_we[gi] = cap_en_reg && (cap_cnt_reg == CNT_W'(gi));
    end
  endgenerate

  // Next-state and datapath logic.
  always_comb begin
    state_next     = state_reg;
    rd_en_next     = 1'b0;
    rd_addr_next   = rd_addr_reg;
    issue_cnt_next = issue_cnt_reg;
    cap_en_next    = rd_en_reg;
    cap_cnt_next   = cap_cnt_reg;
    key_next       = key_reg;
    key_valid_next = key_valid_reg;
    err_next       = 1'b0;

    // Capture the returning word (active in READ and DRAIN only).
    for (int i = 0; i < KEY_WORDS; i++) begin
      if (word_we[i]) begin
        key_next[i*DATA_W +: DATA_W] = bus.rd_data;
      end
    end
    if (cap_en_reg) begin
      cap_cnt_next = cap_cnt_reg + CNT_W'(1);
    end

    unique case (state_reg)
      IDLE: begin
        if (req) begin
          if (slot_ok) begin
            // The base address goes straight into rd_addr; the first word
            // is issued in the very next cycle.
            state_next     = READ;
            rd_en_next     = 1'b1;
            rd_addr_next   = slot_addr;
            issue_cnt_next = CNT_W'(1);
            cap_cnt_next   = '0;
            key_next       = '0;
            key_valid_next = 1'b0;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      READ: begin
        if (issue_cnt_reg == CNT_W'(KEY_WORDS)) begin
          state_next = DRAIN;
        end else begin
          rd_en_next     = 1'b1;
          rd_addr_next   = rd_addr_reg + ADDR_W'(1);
          issue_cnt_next = issue_cnt_reg + CNT_W'(1);
        end
      end

      DRAIN: begin
        // The final word is written by the capture logic above.
        state_next     = VALID;
        key_valid_next = 1'b1;
        issue_cnt_next = '0;
        cap_cnt_next   = '0;
      end

      VALID: begin
        if (bus.key_ready) begin
          state_next     = IDLE;
          key_valid_next = 1'b0;
`ifdef CRYPTO_KEY_AUTOCLEAR_EN
          key_next       = '0;
`endif
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Zeroize overrides everything, including a simultaneous request.
    if (zeroize) begin
      state_next     = IDLE;
      rd_en_next     = 1'b0;
      rd_addr_next   = '0;
      issue_cnt_next = '0;
      cap_en_next    = 1'b0;
      cap_cnt_next   = '0;
      key_next       = '0;
      key_valid_next = 1'b0;
      err_next       = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_en_reg     <= 1'b0;
      rd_addr_reg   <= '0;
      issue_cnt_reg <= '0;
      cap_en_reg    <= 1'b0;
      cap_cnt_reg   <= '0;
      key_reg       <= '0;
      key_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      rd_en_reg     <= rd_en_next;
      rd_addr_reg   <= rd_addr_next;
      issue_cnt_reg <= issue_cnt_next;
      cap_en_reg    <= cap_en_next;
      cap_cnt_reg   <= cap_cnt_next;
      key_reg       <= key_next;
      key_valid_reg <= key_valid_next;
      err_reg       <= err_next;
    end
  end

  assign busy          = (state_reg != IDLE);
  assign err           = err_reg;
  assign bus.rd_en     = rd_en_reg;
  assign bus.rd_addr   = rd_addr_reg;
  assign bus.key_out   = key_reg;
  assign bus.key_valid = key_valid_reg;

endmodule

// File: tb/tb_crypto_key_reader.sv
// Testbench for crypto_key_reader. A registered-read store model feeds the
// main instance (defaults); a second instance with NUM_SLOTS=3 exercises
// the invalid-slot path. Expected keys come from a table and, in the
// randomized phase, from reading the store array directly.
module tb_crypto_key_reader;

  localparam int DATA_W    = 16;
  localparam int KEY_WORDS = 8;
  localparam int SLOT_W    = 2;
  localparam int ADDR_W    = 5;
  localparam int KEY_W     = DATA_W * KEY_WORDS;

  logic clk = 1'b0;
  logic resetn;
  logic req, req2, zeroize;
  logic [SLOT_W-1:0] req_slot, req_slot2;
  logic busy, err, busy2, err2;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  crypto_key_reader_if #(.DATA_W(DATA_W), .KEY_WORDS(KEY_WORDS), .ADDR_W(ADDR_W)) bus ();
  crypto_key_reader_if #(.DATA_W(DATA_W), .KEY_WORDS(KEY_WORDS), .ADDR_W(ADDR_W)) bus2 ();

  crypto_key_reader #(
    .DATA_W(DATA_W), .KEY_WORDS(KEY_WORDS), .NUM_SLOTS(4), .SLOT_W(SLOT_W), .ADDR_W(ADDR_W)
  ) u_dut (
    .clk(clk), .resetn(resetn), .req(req), .req_slot(req_slot), .zeroize(zeroize),
    .busy(busy), .err(err), .bus(bus.master)
  );

  crypto_key_reader #(
    .DATA_W(DATA_W), .KEY_WORDS(KEY_WORDS), .NUM_SLOTS(3), .SLOT_W(SLOT_W), .ADDR_W(ADDR_W)
  ) u_dut3 (
    .clk(clk), .resetn(resetn), .req(req2), .req_slot(req_slot2), .zeroize(zeroize),
    .busy(busy2), .err(err2), .bus(bus2.master)
  );

  always #5 clk = ~clk;

  // Store model: registered read, data valid one cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end
  assign bus2.rd_data   = 16'hA5A5;
  assign bus2.key_ready = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [KEY_W-1:0] model_key(input int slot);
    logic [KEY_W-1:0] k;
    for (int i = 0; i < KEY_WORDS; i++) k[i*DATA_W +: DATA_W] = mem[slot*KEY_WORDS + i];
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch transaction. zero_at = edge index (0 = req edge) after which
  // zeroize is raised, -1 for none.
  task automatic fetch(input int slot, input int ready_wait, input int zero_at,
                       input bit poke, input logic [KEY_W-1:0] exp_key);
    logic [ADDR_W-1:0] addrs[$];
    logic [KEY_W-1:0] held, exp_after;
    bit hold_ok, stale;
    int k;
    req = 1'b1;
    req_slot = SLOT_W'(slot);
    bus.key_ready = (ready_wait == 0);
    tick();
    req = 1'b0;
    chk("busy_start", busy, 1);
    chk("err_valid_slot", err, 0);
    chk("key_clear_start", bus.key_out, 0);
    k = 0;
    while (k < 40) begin
      if (bus.rd_en) addrs.push_back(bus.rd_addr);
      if (zero_at == k) begin
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("zero_key", bus.key_out, 0);
        chk("zero_valid", bus.key_valid, 0);
        chk("zero_rd_en", bus.rd_en, 0);
        chk("zero_busy", busy, 0);
        stale = 1'b0;
        repeat (KEY_WORDS + 3) begin
          tick();
          if (bus.rd_en || bus.key_valid || busy || bus.key_out != '0) stale = 1'b1;
        end
        chk("zero_quiet", stale, 0);
        bus.key_ready = 1'b0;
        $display("fetch slot=%0d wait=%0d zeroized_at=%0d", slot, ready_wait, zero_at);
        return;
      end
      if (k == 1) chk("key_empty_k1", bus.key_out, 0);
      if (bus.key_valid) break;
      tick();
      k++;
    end
    chk("latency", k, KEY_WORDS + 1);
    if (!bus.key_valid) begin
      bus.key_ready = 1'b0;
      $display("fetch slot=%0d timed out", slot);
      return;
    end
    chk("rd_count", addrs.size(), KEY_WORDS);
    for (int i = 0; i < addrs.size() && i < KEY_WORDS; i++)
      chk("rd_addr", addrs[i], slot*KEY_WORDS + i);
    chk("key_value", bus.key_out, exp_key);
    held = bus.key_out;
    if (ready_wait > 0) begin
      hold_ok = 1'b1;
      for (int w = 0; w < ready_wait; w++) begin
        req = poke && (w % 2 == 0);
        req_slot = 2'd1;
        tick();
        req = 1'b0;
        if (!bus.key_valid || bus.key_out !== held || bus.rd_en || err || !busy) hold_ok = 1'b0;
      end
      chk("valid_hold", hold_ok, 1);
      bus.key_ready = 1'b1;
    end
    tick();
    bus.key_ready = 1'b0;
`ifdef CRYPTO_KEY_AUTOCLEAR_EN
    exp_after = '0;
`else
    exp_after = exp_key;
`endif
    chk("valid_drop", bus.key_valid, 0);
    chk("busy_idle", busy, 0);
    chk("key_after_hs", bus.key_out, exp_after);
    tick();
    chk("no_queued_rd", bus.rd_en, 0);
    chk("key_idle_hold", bus.key_out, exp_after);
    $display("fetch slot=%0d wait=%0d key=%032h", slot, ready_wait, held);
  endtask

  typedef struct {
    int slot;
    int ready_wait;
    int zero_at;
    bit poke;
    logic [KEY_W-1:0] exp_key;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2, 0,  -1, 1'b0, 128'h1007_1006_1005_1004_1003_1002_1001_1000};
    vecs[1] = '{0, 20, -1, 1'b1, 128'h1207_1206_1205_1204_1203_1202_1201_1200};
    vecs[2] = '{3, 3,  -1, 1'b0, 128'h1107_1106_1105_1104_1103_1102_1101_1100};
    vecs[3] = '{2, 0,   3, 1'b0, 128'h0};
    vecs[4] = '{1, 2,  -1, 1'b0, 128'h1307_1306_1305_1304_1303_1302_1301_1300};
    vecs[5] = '{1, 4,   9, 1'b0, 128'h0};

    for (int a = 0; a < (1 << ADDR_W); a++)
      mem[a] = 16'(32'h1000 + ((a / KEY_WORDS) ^ 2) * 256 + a % KEY_WORDS);

    resetn = 1'b0;
    req = 1'b0; req2 = 1'b0; zeroize = 1'b0;
    req_slot = '0; req_slot2 = '0;
    bus.key_ready = 1'b0;

    // Reset state, then five idle cycles.
    repeat (3) tick();
    chk("rst_key", bus.key_out, 0);
    chk("rst_addr", bus.rd_addr, 0);
    resetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_key", bus.key_out, 0);
      chk("idle_valid", bus.key_valid, 0);
      chk("idle_rd_en", bus.rd_en, 0);
      chk("idle_busy", busy, 0);
      chk("idle_err", err, 0);
    end

    // Table-driven fetches.
    for (int v = 0; v < 6; v++)
      fetch(vecs[v].slot, vecs[v].ready_wait, vecs[v].zero_at, vecs[v].poke, vecs[v].exp_key);

    // req together with zeroize: request dropped.
    req = 1'b1; req_slot = 2'd0; zeroize = 1'b1;
    tick();
    req = 1'b0; zeroize = 1'b0;
    chk("reqzero_busy", busy, 0);
    chk("reqzero_rd_en", bus.rd_en, 0);
    tick();
    chk("reqzero_rd_en2", bus.rd_en, 0);
    $display("req+zeroize dropped");

    // Invalid slot on the NUM_SLOTS=3 instance.
    req2 = 1'b1; req_slot2 = 2'd3;
    tick();
    req2 = 1'b0;
    chk("err_pulse", err2, 1);
    chk("err_busy", busy2, 0);
    chk("err_rd_en", bus2.rd_en, 0);
    tick();
    chk("err_single", err2, 0);
    chk("err_rd_en2", bus2.rd_en, 0);
    chk("err_busy2", busy2, 0);
    req2 = 1'b1; req_slot2 = 2'd2;
    tick();
    req2 = 1'b0;
    chk("slot2_no_err", err2, 0);
    chk("slot2_busy", busy2, 1);
    chk("slot2_addr", bus2.rd_addr, 16);
    repeat (12) tick();
    chk("slot2_done", busy2, 0);
    $display("invalid slot err transaction done");

    // Asynchronous reset in the middle of READ.
    req = 1'b1; req_slot = 2'd3;
    tick();
    req = 1'b0;
    repeat (3) tick();
    #2 resetn = 1'b0;
    #1;
    chk("arst_rd_en", bus.rd_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_key", bus.key_out, 0);
    chk("arst_addr", bus.rd_addr, 0);
    tick();
    resetn = 1'b1;
    begin
      bit quiet = 1'b1;
      repeat (12) begin
        tick();
        if (bus.rd_en || bus.key_valid || busy) quiet = 1'b0;
      end
      chk("arst_quiet", quiet, 1);
    end
    $display("async reset mid-read done");

    // Randomized fetches against the store-array model.
    for (int it = 0; it < 24; it++) begin
      int s, w, z;
      for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 16'($urandom);
      s = $urandom_range(0, 3);
      w = $urandom_range(0, 6);
      z = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 9) : -1;
      fetch(s, w, z, 1'($urandom_range(0, 1)), model_key(s));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crypto_key_reader.md
Name: crypto_key_reader

Overview:
- Read-side counterpart of the crypto key store.
- On request, fetches one key slot from the store as KEY_WORDS consecutive 16-bit words.
- Assembles the words into a wide key register and hands the key to the cipher core over a valid/ready handshake.
- Supports zeroization, and guarantees no stale or uninitialized key material is ever presented.

Parameters:
- DATA_W, 16, width of one key-store word.
- KEY_WORDS, 8, words per key (key width = DATA_W*KEY_WORDS = 128).
- NUM_SLOTS, 4, number of key slots in the store.
- SLOT_W, 2, width of the slot index.
- ADDR_W, 5, width of the store word address; must satisfy 2**ADDR_W >= NUM_SLOTS*KEY_WORDS.

Ports:
- clk  in  1  Clock; all logic is rising-edge.
- resetn  in  1  Asynchronous active-low reset.
- req  in  1  Request a key fetch; sampled only in IDLE.
- req_slot  in  SLOT_W  Slot index; sampled with req.
- zeroize  in  1  Clear the key buffer and abort any operation.
- busy  out  1  High in any state other than IDLE.
- err  out  1  One-cycle pulse when a request names an invalid slot.
- rd_en  out  1  Store read strobe.
- rd_addr  out  ADDR_W  Store word address.
- rd_data  in  DATA_W  Store read data, valid exactly 1 cycle after rd_en.
- key_out  out  DATA_W*KEY_WORDS  Assembled key.
- key_valid  out  1  Key available to the consumer.
- key_ready  in  1  Consumer accepts the key.

Behaviour:
- Reset (resetn low, asynchronous): all registers clear.
  - State = IDLE.
  - busy, err, rd_en, key_valid = 0.
  - rd_addr = 0, key_out = 0, word counters = 0.
- States:
  - IDLE: waiting for req.
  - READ: issuing reads.
  - DRAIN: capturing the final word.
  - VALID: key presented to the consumer.
- IDLE:
  - req=1 with req_slot < NUM_SLOTS: latch base = req_slot*KEY_WORDS, clear the buffer, go to READ.
  - req=1 with req_slot >= NUM_SLOTS: err=1 for exactly 1 cycle, stay in IDLE, no rd_en.
- READ:
  - rd_en=1 for exactly KEY_WORDS consecutive cycles.
  - rd_addr = base + issue count (0..KEY_WORDS-1).
  - rd_data is captured on the edge after each rd_en cycle; word i goes to key_out[i*DATA_W +: DATA_W].
  - After the last issue, go to DRAIN (rd_en=0).
- DRAIN: capture the last word; key_valid=1 from that edge; go to VALID.
- Latency: key_valid rises KEY_WORDS+1 cycles after the edge that samples req (9 cycles at defaults).
- VALID:
  - key_valid stays 1 and key_out stays stable until key_valid & key_ready.
  - On that handshake: key_valid=0 next cycle, return to IDLE.
  - key_ready is ignored in every other state.
- req outside IDLE: ignored; no queuing and no err.
- zeroize:
  - Highest priority, in any state, including mid-READ.
  - Next edge: key_out=0, key_valid=0, rd_en=0, counters cleared, state = IDLE.
  - If req and zeroize are high together, zeroize wins and req is dropped.
- Reset mid-operation: same end result as zeroize, but asynchronous.
- Address arithmetic: unsigned, ADDR_W bits, no wrap (guaranteed by the slot check).
- The store's write path is independent; reads are not blocked by writes.

Optional Feature:
- Macro: CRYPTO_KEY_AUTOCLEAR_EN.
- Defined: on a completed key_valid & key_ready handshake, key_out is cleared to 0 on the same edge that drops key_valid. key_out is nonzero only while key_valid=1 or a fetch is in progress.
- Undefined: key_out retains the last key after the handshake, until the next fetch start, zeroize or reset.

Decomposition:
- Package crypto_key_pkg:
  - state enum (IDLE, READ, DRAIN, VALID).
  - DATA_W default.
  - KEY_W = DATA_W*KEY_WORDS.
  - Function computing slot base address.
- No sub-module: FSM, counters and the key register stay flat in crypto_key_reader.

Test Plan:
- Reset, then idle 5 cycles -> key_out=0, key_valid=0, rd_en=0, busy=0 throughout.
- Store slot 2 words = 0x1000..0x1007; req with req_slot=2, key_ready held 1 ->
  - rd_addr 16..23 on 8 consecutive rd_en cycles;
  - key_valid 9 cycles after the req edge;
  - key_out = 0x1007_1006_..._1000;
  - key_valid high for exactly 1 cycle.
- Fetch slot 0 with key_ready=0 for 20 cycles -> key_valid and key_out stable; req_slot=1 pulses during this time are ignored (no rd_en); the handshake on the ready edge returns to IDLE.
- req_slot=3 with NUM_SLOTS=3 override -> err single-cycle pulse, no rd_en, busy stays 0.
- zeroize on the 4th rd_en cycle -> next cycle rd_en=0, key_out=0, IDLE; a following fetch of slot 1 yields the correct key.
- Handshake completion with CRYPTO_KEY_AUTOCLEAR_EN defined -> key_out=0 next cycle; with the macro undefined -> key_out holds the key.
